// File: rtl/reg_table_arb.sv
// Register-table front end: round-robin write arbiter over NUM_PORTS requesters,
// banked 512x16 register array and a registered host read port.
module reg_table_arb #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        port_req,
    input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] port_din,
    output logic [NUM_PORTS-1:0]        port_ack,
    input  logic                        host_rd,
    input  logic [ADDR_W+1:0]           host_addr,
    output logic [DATA_W-1:0]           host_dout,
    output logic                        host_rvalid,
    output logic [15:0]                 wr_cnt
);

    localparam int DEPTH = 1 << (ADDR_W + 2);

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_rr_ptr;
    logic [NUM_PORTS-1:0] r_ack;
    logic [15:0]         r_wr_cnt;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
    logic [DATA_W-1:0]   r_dout;
    logic                r_rvalid;

    logic                w_grant_vld;
    logic [1:0]          w_grant;
    logic [1:0]          w_idx;
    logic                w_do_wr;
    logic [ADDR_W+1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;

    // First requester at or after the rotating pointer wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = r_rr_ptr;
        w_idx       = r_rr_ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_grant_vld && port_req[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_do_wr      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_do_wr      = 1'b1;
                    w_next_state = S_ACK;
                end
            end
            S_ACK: begin
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_wr_addr = {w_grant, port_addr[w_grant*ADDR_W +: ADDR_W]};
    assign w_wr_data = port_din[w_grant*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_ack    <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_ack   <= '0;
            if (w_do_wr) begin
                r_ack[w_grant] <= 1'b1;
                r_rr_ptr       <= w_grant + 2'd1;
                r_wr_cnt       <= r_wr_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_wr) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Read samples the pre-write contents, so a same-edge collision returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout   <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= host_rd;
            if (host_rd) r_dout <= r_mem[host_addr];
        end
    end

    assign port_ack    = r_ack;
    assign host_dout   = r_dout;
    assign host_rvalid = r_rvalid;
    assign wr_cnt      = r_wr_cnt;

endmodule

// File: doc/reg_table_arb.md
# reg_table_arb

Register-table front end that sits directly downstream of the per-port statistics writers. It accepts write requests from `NUM_PORTS` requesters over a level-req / pulse-ack handshake and arbitrates them round-robin. Each granted write lands in a banked 16-bit register array indexed by {port index, register address}. A host read port exposes the array to the management side.

## Interface
- `NUM_PORTS`, 4: number of requesting ports; fixed at 4, so the bank index is 2 bits.
- `ADDR_W`, 7: per-port register address width.
- `DATA_W`, 16: register data width.
- Reset is `rst_n`, asynchronous, active-low. The clock is `clk`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `port_req`  in  NUM_PORTS  per-port write request; level, held until acked.
- `port_addr`  in  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*7 +: 7].
- `port_din`  in  NUM_PORTS*DATA_W  per-port write data; port i occupies bits [i*16 +: 16].
- `port_ack`  out  NUM_PORTS  one-cycle ack pulse per port.
- `host_rd`  in  1  host read strobe.
- `host_addr`  in  9  host read address, {port[1:0], addr[6:0]}.
- `host_dout`  out  16  read data.
- `host_rvalid`  out  1  read data valid.
- `wr_cnt`  out  16  count of completed writes; wraps.

## Operation
- Storage is a 512 x 16 array, all entries 0 after reset. A write from port i to address a stores `port_din[i]` at {i, a}.
- The arbiter FSM has two states, IDLE and ACK.
  - **IDLE:** if any `port_req` bit is set, grant the first requesting port at or after `rr_ptr`, searching ascending and wrapping 3 -> 0. On the grant edge, write the array, set `rr_ptr` to grant+1 mod 4, register `port_ack[grant]` = 1, and go to ACK. If no request is set, stay in IDLE.
  - **ACK:** `port_ack[grant]` is high for this single cycle and drops on the next edge. No arbitration happens in ACK. The acked requester's `req` is still high during ACK and must not be re-granted. Return to IDLE.
- Multiple simultaneous requests are served in rotating order. Each gets exactly one ack, and the maximum wait is 2*(NUM_PORTS-1) cycles after the first eligible IDLE cycle.
- At most one `port_ack` bit is high in any cycle.
- A `port_req` that drops before its grant is simply not served; nothing is written.
- `wr_cnt` increments by 1 on each grant edge and wraps from 0xFFFF to 0x0000.
- **Host read:** when `host_rd` is sampled high, the array at `host_addr` is registered into `host_dout`, and `host_rvalid` is 1 for exactly one cycle. If `host_rd` is high for N consecutive cycles, `host_rvalid` is high for N cycles with pipelined data.
- **Read/write collision:** if `host_rd` and a grant target the same entry in the same cycle, `host_dout` returns the old value. The new value is visible from the next read onward.
- `host_dout` holds its last value when `host_rvalid` = 0.

## Timing
- **Reset values:**
  - `port_ack` = 0, `host_dout` = 0, `host_rvalid` = 0, `wr_cnt` = 0.
  - State = IDLE, `rr_ptr` = 0, array = 0.
- **Write latency:** `req` is sampled high in IDLE at edge E. The array is updated at E, and `port_ack` is high from E to E+1.
- A requester that drops `req` on the edge after seeing ack can immediately re-request. The earliest regrant of the same port is E+2, and only if no other port is pending under round-robin.
- **Throughput:** one write per 2 cycles sustained.
- **Read latency:** 1 cycle from `host_rd` sampled to `host_rvalid`/`host_dout`.
- **Reset mid-operation:** asserting `rst_n` low clears `port_ack` and `host_rvalid` immediately (asynchronously). A pending handshake is abandoned, and the requester must re-request after reset.

## Test plan
- **Single write:** port 1 req with addr 0x10 and din 0x1234. Required: `port_ack[1]` high exactly 1 cycle, 1 cycle after req is sampled. A subsequent host read of 0x090 returns 0x1234 with `host_rvalid` 1 cycle later. `wr_cnt` = 1.
- **Contention:** all 4 ports request in the same cycle with addr 0x11 and din 0xA0+i. Required: acks arrive in order 0, 1, 2, 3, spaced 2 cycles apart. Reads of 0x011, 0x091, 0x111, 0x191 return 0xA0 to 0xA3.
- **Round-robin fairness:** ports 0 and 2 keep re-requesting continuously. Required: grants alternate 0, 2, 0, 2, and no port is ever acked twice in a row while the other is pending.
- **Collision:** `host_rd` at 0x012 in the same cycle as the port 0 grant writing 0x5555 over 0x0000. Required: `host_dout` = 0x0000. The next read returns 0x5555.
- **Wrap:** preload `wr_cnt` via 65535 writes, then perform one more. Required: `wr_cnt` = 0x0000.
- **Reset mid-handshake:** assert `rst_n` low while `port_ack[3]` is high. Required: ack drops immediately. After release, all outputs are 0, and reads of previously written entries return 0.
